// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the iterative shift unit: the op-code encodings and
// the controller state type.
// Optional feature macro: SHIFT_SRL_EN (op 2'b10 becomes a logical right shift).
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// One power-of-two stage of the iterative shifter. Purely combinational.
// When enabled, the accumulator is shifted by 2^k according to the op code.
// When disabled, or when the op is reserved, the accumulator passes through.
// Optional feature macro: SHIFT_SRL_EN adds the zero-fill right-shift leg.
//
// Ports:
//   i_acc  [DATA_W-1:0]  current accumulator value
//   i_k    [KW-1:0]      stage index; the shift distance is 2^i_k
//   i_op   [1:0]         OP_SLL / OP_SRA / OP_SRL (macro only) / reserved
//   i_en                 shift-amount bit for this stage
//   o_acc  [DATA_W-1:0]  accumulator after this stage
// -----------------------------------------------------------------------------
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int SHAMT_W = $clog2(DATA_W),
  localparam int KW = $clog2(SHAMT_W)
) (
  input  logic [DATA_W-1:0] i_acc,
  input  logic [KW-1:0]     i_k,
  input  logic [1:0]        i_op,
  input  logic              i_en,
  output logic [DATA_W-1:0] o_acc
);

  logic [DATA_W-1:0] w_dist;

  // Shift the accumulator by 2^k; SRA re-samples the MSB on every stage.
  always_comb begin
    w_dist = {{(DATA_W-1){1'b0}}, 1'b1} << i_k;
    o_acc  = i_acc;
    if (i_en) begin
      case (i_op)
        OP_SLL:  o_acc = i_acc << w_dist;
        OP_SRA:  o_acc = $signed(i_acc) >>> w_dist;
`ifdef SHIFT_SRL_EN
        OP_SRL:  o_acc = i_acc >> w_dist;
`endif
        default: o_acc = i_acc;
      endcase
    end else begin
      o_acc = i_acc;
    end
  end

endmodule

// File: rtl/shift_iter.sv
// -----------------------------------------------------------------------------
// shift_iter
// Iterative DATA_W-bit shift unit. A request is captured in IDLE, then one
// power-of-two stage (2^(SHAMT_W-1) down to 1) is applied per clock, so every
// operation spends exactly SHAMT_W cycles in SHIFT regardless of the shift
// amount. The result is presented in DONE until the consumer takes it.
// Optional feature macro: SHIFT_SRL_EN (op 2'b10 performs a logical right
// shift; otherwise it passes the operand through like the reserved op).
//
// Ports:
//   clock          rising-edge clock
//   resetn         asynchronous active-low reset; aborts any operation
//   in_valid       request present
//   in_ready       unit can accept a request (registered, high only in IDLE)
//   data_operandA  operand to shift
//   ctrl_shiftamt  shift distance, 0..DATA_W-1
//   ctrl_op        2'b00 SLL, 2'b01 SRA, 2'b10 SRL (macro only), 2'b11 reserved
//   out_valid      result valid (registered, high only in DONE)
//   out_ready      consumer takes the result
//   data_result    shifted result, stable while out_valid is high
// -----------------------------------------------------------------------------
module shift_iter
  import shift_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int SHAMT_W = $clog2(DATA_W),
  localparam int KW = $clog2(SHAMT_W)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  input  logic [1:0]         ctrl_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  data_result
);

  localparam logic [KW-1:0] K_LAST  = KW'(SHAMT_W - 1);
  localparam logic [KW-1:0] K_FIRST = KW'(0);

  shift_state_t       r_state;
  shift_state_t       w_state_next;
  logic [DATA_W-1:0]  r_acc;
  logic [SHAMT_W-1:0] r_shamt;
  logic [1:0]         r_op;
  logic [KW-1:0]      r_k;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_result;
  logic               w_accept;
  logic               w_stage_en;
  logic [DATA_W-1:0]  w_stage_out;

  assign w_accept    = in_valid && r_in_ready;
  assign w_stage_en  = r_shamt[r_k];
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign data_result = r_result;

  // Single shared stage, stepped through k = SHAMT_W-1 .. 0.
  shift_stage #(.DATA_W(DATA_W)) u_stage (
    .i_acc (r_acc),
    .i_k   (r_k),
    .i_op  (r_op),
    .i_en  (w_stage_en),
    .o_acc (w_stage_out)
  );

  // Next-state logic for the IDLE -> SHIFT -> DONE controller.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SHIFT;
        end else begin
          w_state_next = IDLE;
        end
      end
      SHIFT: begin
        if (r_k == K_FIRST) begin
          w_state_next = DONE;
        end else begin
          w_state_next = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_shamt     <= '0;
      r_op        <= OP_SLL;
      r_k         <= K_LAST;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      r_state     <= w_state_next;
      // Handshake flags follow the next state so they line up with it.
      r_in_ready  <= (w_state_next == IDLE);
      r_out_valid <= (w_state_next == DONE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= data_operandA;
            r_shamt <= ctrl_shiftamt;
            r_op    <= ctrl_op;
            r_k     <= K_LAST;
          end
        end
        SHIFT: begin
          r_acc <= w_stage_out;
          if (r_k == K_FIRST) begin
            // Result register only ever sees the completed value.
            r_result <= w_stage_out;
            r_k      <= K_LAST;
          end else begin
            r_k <= r_k - KW'(1);
          end
        end
        DONE: begin
          r_acc <= r_acc;
        end
        default: begin
          r_k <= K_LAST;
        end
      endcase
    end
  end

endmodule
